// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an 8:1 mux select, samples each channel after a settle delay,
// and presents the packed byte on a valid/ready port without ever dropping one.
module mux_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic [2:0] s,
  output logic       busy,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready
);
  typedef enum logic [1:0] {IDLE, SETL, SAMPLE, HOLD} state_t;
  localparam logic [3:0] CNT0 = 4'(SETTLE == 0 ? 0 : SETTLE - 1);
  localparam state_t FIRST = (SETTLE == 0) ? SAMPLE : SETL;
  state_t state;
  logic [7:0] asm_q;
  logic [3:0] cnt;
  logic slot_free;
  assign slot_free = !q_valid || q_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      asm_q   <= '0;
      cnt     <= '0;
    end else begin
      if (q_valid && q_ready) q_valid <= 1'b0;
      case (state)
        IDLE: if (start || cont) begin
          state <= FIRST;
          cnt   <= CNT0;
        end
        SETL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= SAMPLE;
        end
        SAMPLE: begin
          asm_q[s] <= y;
          if (s != 3'd7) begin
            s     <= s + 3'd1;
            state <= FIRST;
            cnt   <= CNT0;
          end else if (slot_free) begin
            q       <= {y, asm_q[6:0]};
            q_valid <= 1'b1;
            s       <= '0;
            state   <= cont ? FIRST : IDLE;
            cnt     <= CNT0;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: if (q_ready) begin
          q       <= asm_q;
          q_valid <= 1'b1;
          s       <= '0;
          state   <= cont ? FIRST : IDLE;
          cnt     <= CNT0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed scan scenarios on SETTLE=2 and SETTLE=0 instances with a byte scoreboard.
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start, cont, q_ready;
  logic start0, cont0, q_ready0;
  logic [7:0] d, d0;
  logic y, y0;
  logic [2:0] s, s0;
  logic busy, busy0, q_valid, q_valid0;
  logic [7:0] q, q0;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] sb0[$];

  always #5 clk = ~clk;
  assign y  = d[s];
  assign y0 = d0[s0];

  mux_scan_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .y(y), .s(s),
    .busy(busy), .q(q), .q_valid(q_valid), .q_ready(q_ready)
  );
  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cont(cont0), .y(y0), .s(s0),
    .busy(busy0), .q(q0), .q_valid(q_valid0), .q_ready(q_ready0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted byte must match the oldest expected one.
  always @(negedge clk) begin
    #1;
    if (!rst && q_valid && q_ready) begin
      chk("sb_has_entry", 8'(sb.size() != 0), 8'd1);
      if (sb.size() != 0) chk("sb_byte", q, sb.pop_front());
    end
    if (!rst && q_valid0 && q_ready0) begin
      chk("sb0_has_entry", 8'(sb0.size() != 0), 8'd1);
      if (sb0.size() != 0) chk("sb0_byte", q0, sb0.pop_front());
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; q_ready = 1'b0; d = '0;
    start0 = 1'b0; cont0 = 1'b0; q_ready0 = 1'b1; d0 = '0;
    repeat (2) @(negedge clk);
    chk("rst_s", 8'(s), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_q", q, 8'h00);
    chk("rst_qv", 8'(q_valid), 8'd0);
    chk("rst_qv0", 8'(q_valid0), 8'd0);
    rst = 1'b0;
    // basic scan, SETTLE=2
    d = 8'hA5; q_ready = 1'b1; start = 1'b1; sb.push_back(8'hA5);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 24; t++) begin
      chk("basic_s", 8'(s), 8'(t / 3));
      if (t == 23) chk("basic_busy_hi", 8'(busy), 8'd1);
      @(negedge clk);
    end
    chk("basic_qv", 8'(q_valid), 8'd1);
    chk("basic_q", q, 8'hA5);
    chk("basic_busy_lo", 8'(busy), 8'd0);
    @(negedge clk);
    chk("basic_qv_drop", 8'(q_valid), 8'd0);
    // zero settle
    d0 = 8'h3C; start0 = 1'b1; sb0.push_back(8'h3C);
    @(negedge clk);
    start0 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      chk("zero_s", 8'(s0), 8'(t));
      @(negedge clk);
    end
    chk("zero_qv", 8'(q_valid0), 8'd1);
    chk("zero_q", q0, 8'h3C);
    chk("zero_busy", 8'(busy0), 8'd0);
    // back-pressure
    q_ready = 1'b0; cont = 1'b1; d = 8'h0F;
    sb.push_back(8'h0F); sb.push_back(8'hF0);
    @(negedge clk);
    repeat (24) @(negedge clk);
    chk("bp_qv1", 8'(q_valid), 8'd1);
    chk("bp_q1", q, 8'h0F);
    d = 8'hF0;
    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 0) chk("bp_q_stable", q, 8'h0F);
      @(negedge clk);
    end
    cont = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("bp_hold_s", 8'(s), 8'd7);
      chk("bp_hold_busy", 8'(busy), 8'd1);
      chk("bp_hold_q", q, 8'h0F);
      @(negedge clk);
    end
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    chk("bp_no_gap", 8'(q_valid), 8'd1);
    chk("bp_q2", q, 8'hF0);
    chk("bp_s0", 8'(s), 8'd0);
    chk("bp_idle", 8'(busy), 8'd0);
    q_ready = 1'b1;
    @(negedge clk);
    chk("bp_qv_drop", 8'(q_valid), 8'd0);
    // continuous
    cont = 1'b1; d = 8'h01;
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h04);
    @(negedge clk);
    repeat (24) @(negedge clk);
    chk("cont_q1", q, 8'h01);
    chk("cont_qv1", 8'(q_valid), 8'd1);
    d = 8'h02;
    repeat (24) @(negedge clk);
    chk("cont_q2", q, 8'h02);
    chk("cont_busy2", 8'(busy), 8'd1);
    d = 8'h04;
    repeat (12) @(negedge clk);
    cont = 1'b0;
    repeat (12) @(negedge clk);
    chk("cont_q3", q, 8'h04);
    chk("cont_qv3", 8'(q_valid), 8'd1);
    chk("cont_idle", 8'(busy), 8'd0);
    @(negedge clk);
    chk("cont_idle2", 8'(busy), 8'd0);
    // reset mid-scan
    d = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_s4", 8'(s), 8'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_s", 8'(s), 8'd0);
    chk("mid_busy", 8'(busy), 8'd0);
    chk("mid_qv", 8'(q_valid), 8'd0);
    chk("mid_q", q, 8'h00);
    d = 8'h5A; start = 1'b1; sb.push_back(8'h5A);
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    chk("mid_fresh_q", q, 8'h5A);
    chk("mid_fresh_qv", 8'(q_valid), 8'd1);
    // start while busy
    d = 8'hC3; start = 1'b1; sb.push_back(8'hC3);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("sb_busy_s3", 8'(s), 8'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("swb_q", q, 8'hC3);
    chk("swb_qv", 8'(q_valid), 8'd1);
    chk("swb_idle", 8'(busy), 8'd0);
    repeat (30) @(negedge clk);
    chk("swb_no_second", 8'(q_valid), 8'd0);
    chk("swb_still_idle", 8'(busy), 8'd0);
    chk("sb_drained", 8'(sb.size()), 8'd0);
    chk("sb0_drained", 8'(sb0.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Scan sequencer for the 8:1 data-select mux.
- Drives the 3-bit select, waits a programmable settle time, then samples the mux output for channels 0..7 in order.
- Packs the 8 sampled bits into a byte, presented on a valid/ready output port.
- Sits between the mux (drives its select, consumes its single-bit output) and the downstream byte consumer.

Parameters:
- SETTLE, 2, cycles the select is held stable before each sample; legal range 0..15.

Ports:
- clk, input, 1, single system clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, single-scan request; sampled only in IDLE.
- cont, input, 1, continuous mode; a new scan starts automatically while high.
- y, input, 1, mux output for the currently selected channel.
- s, output, 3, mux select (registered).
- busy, output, 1, high in any state other than IDLE.
- q, output, 8, assembled byte; q[i] is the sample of channel i.
- q_valid, output, 1, q holds an unconsumed byte.
- q_ready, input, 1, consumer accepts q when q_valid and q_ready are both high.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - state=IDLE, s=0, busy=0, q=0, q_valid=0.
  - Shift/assembly register and settle counter cleared.
  - Applies at any state, including mid-scan; the partial byte is discarded.
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - s=0.
  - If start or cont is high: enter SETTLE with counter=SETTLE-1; if SETTLE=0, enter SAMPLE directly.
  - start while busy is ignored; no queuing.
- SETTLE:
  - s held constant; counter decrements each cycle.
  - At counter=0, next state is SAMPLE.
- SAMPLE (exactly 1 cycle):
  - y captured into assembly bit [s].
  - If s<7: s increments and the block re-enters SETTLE (counter=SETTLE-1), or SAMPLE again if SETTLE=0.
  - If s=7: byte complete, go to the output-load decision.
- Output load decision (registered at the edge ending SAMPLE of channel 7):
  - The slot is free if q_valid=0, or if q_valid=1 and q_ready=1 in that same cycle.
  - Free slot: q = assembled byte (bit 7 = current y), q_valid=1. A simultaneous consume and load keeps q_valid high with no bubble.
  - Slot occupied: enter HOLD. The completed byte is kept internally, s stays 7, busy=1.
- HOLD:
  - Each cycle, if q_ready=1, load q from the held byte in that cycle; q_valid stays 1.
  - Then proceed as after a load.
  - No byte is ever dropped.
- After a load:
  - s returns to 0.
  - cont=1 at that edge: enter SETTLE (or SAMPLE if SETTLE=0) for the next scan.
  - Otherwise: IDLE.
  - Dropping cont mid-scan finishes the current byte, then goes to IDLE.
- Output handshake:
  - q and q_valid are stable while q_valid=1 and q_ready=0.
  - q_valid falls on the edge after the accept cycle unless a new byte loads in that same edge.
- Timing (no stall): start seen at edge 0 gives s=0 for SETTLE cycles plus 1 SAMPLE cycle per channel. q_valid rises 8*(SETTLE+1) cycles after the start edge.
- Select behaviour: s only changes on the edge ending a SAMPLE cycle (or on reset, or on return to 0). It is therefore glitch-free relative to the mux input path.

Test Plan:
- Basic scan: rst 2 cycles; SETTLE=2, d=8'hA5 on the mux, start pulse, q_ready=1 -> s steps 0..7, each value held 3 cycles; q=8'hA5 with q_valid high 24 cycles after start; busy low the cycle after.
- Zero settle: SETTLE=0, d=8'h3C, start -> s changes every cycle; q=8'h3C valid 8 cycles after start.
- Back-pressure: cont=1, q_ready=0, d=8'h0F then 8'hF0 -> first byte 8'h0F valid and stable; second scan completes, block sits in HOLD with s=7, busy=1; raising q_ready for one cycle loads 8'hF0 with no q_valid gap; no byte lost.
- Continuous: cont=1, q_ready=1, d rotating 8'h01,8'h02,8'h04 per scan -> q sequence 01,02,04 at 24-cycle spacing (SETTLE=2); dropping cont mid-third-scan still yields 8'h04, then IDLE.
- Reset mid-scan: assert rst while s=4 in SETTLE -> next edge s=0, busy=0, q_valid=0, q=0; a new start gives a fresh full scan.
- Start while busy: pulse start during SAMPLE of channel 3 -> ignored; exactly one byte produced, then IDLE.
